// File: rtl/kara_prod_accumulator_if.sv
// kara_prod_accumulator_if
// Handshake bundle between the Karatsuba multiplier, the product accumulator
// and the accumulator's result consumer.
//   in_valid  / in_ready  : product beat handshake (producer -> accumulator)
//   in_prod               : unsigned 2*DATA_W-bit product
//   in_last               : beat closes the current group
//   out_valid / out_ready : rounded result handshake (accumulator -> consumer)
//   out_data              : rounded, saturated DATA_W-bit result
//   out_sat               : result was clipped to all-ones
//   out_count             : number of terms summed into the result
// The master modport is the environment side (producer + consumer).
// The slave modport is the accumulator side.
interface kara_prod_accumulator_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   in_prod;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic                  out_sat;
    logic [LEN_W-1:0]      out_count;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/kara_prod_accumulator.sv
// kara_prod_accumulator
// Sums a group of unsigned Karatsuba products (one dot-product row) in a
// guard-bit accumulator, then rounds back to DATA_W-bit fixed point by
// dropping FRAC_W LSBs (round half up), saturates to all-ones, and holds
// the result until the consumer takes it.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : kara_prod_accumulator_if.slave (product in, result out)
module kara_prod_accumulator #(
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int LEN_W   = 8,
    parameter int GUARD_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    kara_prod_accumulator_if.slave     bus
);
    localparam int ACC_W = 2*DATA_W + GUARD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_upd;
    logic              beat;
    logic              acc_load;
    logic              acc_add;
    logic              do_round;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    half;
    logic [ACC_W:0]    rounded;
    logic              overflow;

    logic [DATA_W-1:0] data_q;
    logic              sat_q;
    logic [LEN_W-1:0]  count_q;

    // in_ready is forced low while reset is asserted, even though the
    // state register already sits in IDLE.
    assign bus.in_ready  = rst_n && ((state == IDLE) || (state == ACCUM));
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_sat   = sat_q;
    assign bus.out_count = count_q;

    assign beat     = bus.in_valid && bus.in_ready;
    assign prod_ext = {{GUARD_W{1'b0}}, bus.in_prod};

    // One extra bit above the accumulator so the rounding increment never wraps.
    assign half     = (ACC_W+1)'(1) << (FRAC_W - 1);
    assign rounded  = ({1'b0, acc} + half) >> FRAC_W;
    assign overflow = |rounded[ACC_W:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_load  = 1'b0;
        acc_add   = 1'b0;
        do_round  = 1'b0;
        cnt_upd   = '0;
        case (state)
            IDLE: begin
                cnt_upd = LEN_W'(1);
                if (beat) begin
                    acc_load  = 1'b1;
                    state_nxt = (bus.in_last || (cnt_upd == '1)) ? ROUND : ACCUM;
                end
            end
            ACCUM: begin
                cnt_upd = cnt + LEN_W'(1);
                if (beat) begin
                    acc_add   = 1'b1;
                    state_nxt = (bus.in_last || (cnt_upd == '1)) ? ROUND : ACCUM;
                end
            end
            ROUND: begin
                do_round  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
        end else if (acc_load) begin
            acc <= prod_ext;
            cnt <= cnt_upd;
        end else if (acc_add) begin
            acc <= acc + prod_ext;
            cnt <= cnt_upd;
        end else if (do_round) begin
            acc     <= '0;
            cnt     <= '0;
            data_q  <= overflow ? '1 : rounded[DATA_W-1:0];
            sat_q   <= overflow;
            count_q <= cnt;
        end
    end
endmodule

// File: tb/tb_kara_prod_accumulator.sv
module tb_kara_prod_accumulator;
    localparam int DATA_W  = 32;
    localparam int FRAC_W  = 16;
    localparam int LEN_W   = 8;
    localparam int GUARD_W = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sat;
        logic [LEN_W-1:0]  count;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    kara_prod_accumulator_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    kara_prod_accumulator #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .LEN_W  (LEN_W),
        .GUARD_W(GUARD_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic s, input logic [LEN_W-1:0] c);
        exp_t e;
        e.data  = d;
        e.sat   = s;
        e.count = c;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [63:0] prod, input logic last);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_prod  = prod;
        bus.in_last  = last;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check("beat_accept_timeout", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag);
        int   waited;
        exp_t e;
        waited = 0;
        while (!bus.out_valid && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"},  64'(bus.out_data),  64'(e.data));
            check({tag, "_sat"},   64'(bus.out_sat),   64'(e.sat));
            check({tag, "_count"}, 64'(bus.out_count), 64'(e.count));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_sat",   64'(bus.out_sat),   64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Single term, latency check
        push_exp(32'h0001_0000, 1'b0, 8'd1);
        send_beat(64'h0000_0001_0000_0000, 1'b1);
        check("lat_round_valid", 64'(bus.out_valid), 64'd0);
        check("lat_round_ready", 64'(bus.in_ready),  64'd0);
        @(negedge clk);
        check("lat_hold_valid",  64'(bus.out_valid), 64'd1);
        expect_result("one_term");

        // Rounding boundary
        push_exp(32'd1, 1'b0, 8'd1);
        send_beat(64'h0000_0000_0000_8000, 1'b1);
        expect_result("round_up");
        push_exp(32'd0, 1'b0, 8'd1);
        send_beat(64'h0000_0000_0000_7FFF, 1'b1);
        expect_result("round_down");

        // Three-term sum, back-to-back beats
        push_exp(32'd6, 1'b0, 8'd3);
        send_beat(64'h0000_0000_0002_0000, 1'b0);
        send_beat(64'h0000_0000_0002_0000, 1'b0);
        send_beat(64'h0000_0000_0002_0000, 1'b1);
        expect_result("sum3");

        // Saturation
        push_exp(32'hFFFF_FFFF, 1'b1, 8'd2);
        send_beat(64'h0000_FFFF_0000_0000, 1'b0);
        send_beat(64'h0000_FFFF_0000_0000, 1'b1);
        expect_result("sat");

        // Backpressure in HOLD with a beat offered
        push_exp(32'd5, 1'b0, 8'd1);
        send_beat(64'h0000_0000_0005_0000, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_prod  = 64'h0000_0000_0003_0000;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    64'(bus.out_valid), 64'd1);
            check("bp_data",     64'(bus.out_data),  64'd5);
            check("bp_in_ready", 64'(bus.in_ready),  64'd0);
            @(negedge clk);
        end
        expect_result("bp");
        check("bp_keep_data", 64'(bus.out_data), 64'd5);
        push_exp(32'd4, 1'b0, 8'd2);
        send_beat(64'h0000_0000_0003_0000, 1'b0);
        send_beat(64'h0000_0000_0001_0000, 1'b1);
        expect_result("after_bp");

        // Term-count cap without in_last
        push_exp(32'd255, 1'b0, 8'd255);
        for (int i = 0; i < 255; i++) begin
            send_beat(64'h0000_0000_0001_0000, 1'b0);
        end
        expect_result("cap");

        // Reset mid-group discards partial sum
        send_beat(64'h0000_0000_0001_0000, 1'b0);
        send_beat(64'h0000_0000_0001_0000, 1'b0);
        send_beat(64'h0000_0000_0001_0000, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  64'(bus.in_ready),  64'd0);
        check("midrst_out_count", 64'(bus.out_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_valid", 64'(bus.out_valid), 64'd0);
        end
        push_exp(32'd2, 1'b0, 8'd1);
        send_beat(64'h0000_0000_0002_0000, 1'b1);
        expect_result("post_rst");

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
